// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-back path.
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot register mask; x0 never appears in any mask.
    function automatic logic [NUM_REGS-1:0] rd_mask(
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[rd] = (rd != '0);
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO for long-latency write-back requests.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    wb_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_FULL);
    assign count = r_count;

    assign w_do_pop  = pop & ~empty;
    // A full FIFO may take a push only when the head leaves this cycle.
    assign w_do_push = push & (~full | w_do_pop);

    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write port master: ALU/long-latency arbitration,
// registered write port and busy-register scoreboard.
module rf_writeback_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [4:0]            alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ll_valid,
    output logic                  ll_ready,
    input  logic [4:0]            ll_rd,
    input  logic [XLEN-1:0]       ll_data,
    input  logic                  iss_valid,
    input  logic [4:0]            iss_rd,
    input  logic [4:0]            chk_rs1,
    input  logic [4:0]            chk_rs2,
    input  logic [4:0]            chk_rd,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  reg_wr,
    output logic [4:0]            wr_reg,
    output logic [XLEN-1:0]       wr_data
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wb_req_t               w_push_req;
    wb_req_t               w_head;
    wb_req_t               w_sel;
    logic                  w_sel_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;
    logic [NUM_REGS-1:0]   w_chk;

    logic                  r_reg_wr;
    logic [4:0]            r_wr_reg;
    logic [XLEN-1:0]       r_wr_data;
    logic [NUM_REGS-1:0]   r_busy;

    assign ll_ready   = (w_count != CNT_FULL);
    assign w_push     = ll_valid & ~w_full;
    assign w_pop      = ~alu_valid & ~w_empty;
    assign w_push_req = '{rd: ll_rd, data: ll_data};

    wb_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_req),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_sel       = w_head;
        w_sel_valid = 1'b0;
        unique case (1'b1)
            alu_valid: begin
                w_sel       = '{rd: alu_rd, data: alu_data};
                w_sel_valid = 1'b1;
            end
            w_pop: begin
                w_sel       = w_head;
                w_sel_valid = 1'b1;
            end
            default: begin
                w_sel_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_wr  <= 1'b0;
            r_wr_reg  <= '0;
            r_wr_data <= '0;
        end else begin
            r_reg_wr <= w_sel_valid & (w_sel.rd != '0);
            if (w_sel_valid) begin
                r_wr_reg  <= w_sel.rd;
                r_wr_data <= w_sel.data;
            end
        end
    end

    // Set is OR'd in after the clear so a re-issue in the pop cycle wins.
    assign w_set = iss_valid ? rd_mask(iss_rd) : '0;
    assign w_clr = w_pop ? rd_mask(w_head.rd) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign w_chk = rd_mask(chk_rs1) | rd_mask(chk_rs2) | rd_mask(chk_rd);
    assign stall = |(r_busy & w_chk);

    assign busy    = r_busy;
    assign reg_wr  = r_reg_wr;
    assign wr_reg  = r_wr_reg;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed checks for the register-file write-back arbiter.
module tb_rf_writeback_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        stall;
    logic [31:0] busy;
    logic        reg_wr;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;

    int n_chk  = 0;
    int n_pass = 0;

    rf_writeback_arbiter #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ll_valid  (ll_valid),
        .ll_ready  (ll_ready),
        .ll_rd     (ll_rd),
        .ll_data   (ll_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .chk_rd    (chk_rd),
        .stall     (stall),
        .busy      (busy),
        .reg_wr    (reg_wr),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ll_valid = 0; ll_rd = 0; ll_data = 0;
        iss_valid = 0; iss_rd = 0;
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        #2;
        chk("rst_reg_wr", reg_wr, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ll_ready", ll_ready, 1);
        chk("rst_stall", stall, 0);
        tick(); tick();
        rst = 1'b0;

        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick();
        chk("alu_reg_wr", reg_wr, 1);
        chk("alu_wr_reg", wr_reg, 5);
        chk("alu_wr_data", wr_data, 32'hDEADBEEF);
        alu_valid = 0;
        tick();
        chk("idle_reg_wr", reg_wr, 0);
        chk("idle_hold_reg", wr_reg, 5);
        chk("idle_hold_data", wr_data, 32'hDEADBEEF);

        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        tick();
        chk("x0_alu_drop", reg_wr, 0);
        alu_valid = 0;
        iss_valid = 1; iss_rd = 0;
        tick();
        chk("x0_iss_busy", busy, 0);

        iss_rd = 7;
        tick();
        iss_valid = 0;
        chk("iss7_busy", busy, 32'h80);
        chk("conf_ready", ll_ready, 1);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
        ll_valid = 1; ll_rd = 7; ll_data = 32'h77;
        tick();
        alu_valid = 0; ll_valid = 0;
        chk("conf1_reg_wr", reg_wr, 1);
        chk("conf1_wr_reg", wr_reg, 3);
        chk("conf1_wr_data", wr_data, 32'h33);
        chk("conf1_busy", busy, 32'h80);
        tick();
        chk("conf2_reg_wr", reg_wr, 1);
        chk("conf2_wr_reg", wr_reg, 7);
        chk("conf2_wr_data", wr_data, 32'h77);
        chk("conf2_busy", busy, 0);
        tick();
        chk("conf3_reg_wr", reg_wr, 0);

        alu_valid = 1; alu_rd = 1; alu_data = 32'h1111;
        ll_valid = 1; ll_rd = 8; ll_data = 32'h88;
        tick();
        chk("bp1_ready", ll_ready, 1);
        chk("bp1_wr_reg", wr_reg, 1);
        ll_rd = 9; ll_data = 32'h99;
        tick();
        chk("bp2_ready", ll_ready, 0);
        ll_rd = 11; ll_data = 32'hBB;
        tick();
        chk("bp3_ready", ll_ready, 0);
        chk("bp3_reg_wr", reg_wr, 1);
        chk("bp3_wr_reg", wr_reg, 1);
        ll_valid = 0; alu_valid = 0;
        tick();
        chk("drain8_reg_wr", reg_wr, 1);
        chk("drain8_wr_reg", wr_reg, 8);
        chk("drain8_wr_data", wr_data, 32'h88);
        chk("drain8_ready", ll_ready, 1);
        tick();
        chk("drain9_wr_reg", wr_reg, 9);
        chk("drain9_wr_data", wr_data, 32'h99);
        chk("drain9_ready", ll_ready, 1);
        tick();
        chk("drain_empty", reg_wr, 0);

        iss_valid = 1; iss_rd = 10;
        tick();
        iss_valid = 0;
        chk("sb_busy10", busy, 32'h400);
        chk_rs2 = 10; #1;
        chk("sb_stall_rs2", stall, 1);
        chk_rs2 = 0; chk_rs1 = 10; #1;
        chk("sb_stall_rs1", stall, 1);
        chk_rs1 = 0; chk_rd = 10; #1;
        chk("sb_stall_rd", stall, 1);
        chk_rd = 11; #1;
        chk("sb_nostall", stall, 0);
        chk_rd = 0; chk_rs2 = 10; #1;
        ll_valid = 1; ll_rd = 10; ll_data = 32'hAAAA;
        tick();
        ll_valid = 0;
        chk("sb_pre_pop_stall", stall, 1);
        chk("sb_pre_pop_wr", reg_wr, 0);
        tick();
        chk("sb_pop_reg_wr", reg_wr, 1);
        chk("sb_pop_wr_reg", wr_reg, 10);
        chk("sb_pop_stall", stall, 0);
        chk("sb_pop_busy", busy, 0);

        iss_valid = 1; iss_rd = 10;
        tick();
        iss_valid = 0;
        ll_valid = 1; ll_rd = 10; ll_data = 32'hBBBB;
        tick();
        ll_valid = 0;
        iss_valid = 1; iss_rd = 10;
        tick();
        iss_valid = 0;
        chk("reiss_reg_wr", reg_wr, 1);
        chk("reiss_wr_data", wr_data, 32'hBBBB);
        chk("reiss_busy", busy, 32'h400);
        chk("reiss_stall", stall, 1);

        alu_valid = 1; alu_rd = 2; alu_data = 32'h2222;
        ll_valid = 1; ll_rd = 12; ll_data = 32'hCC;
        tick();
        ll_valid = 0;
        chk("mid_wr_reg", wr_reg, 2);
        chk("mid_busy", busy, 32'h400);
        rst = 1'b1; #1;
        chk("mid_rst_reg_wr", reg_wr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ll_ready, 1);
        chk("mid_rst_stall", stall, 0);
        alu_valid = 0;
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_no_write", reg_wr, 0);
        chk("post_rst_wr_reg", wr_reg, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
